// File: rtl/divide_rv.sv
// divide_rv: multi-cycle RISC-V M-extension divide unit (DIV, DIVU, REM, REMU).
// Restoring division retiring BITS_PER_CYCLE quotient bits per cycle, with
// early-out on divide-by-zero, signed overflow and |divisor| > |dividend|.
// The result is held for the CDB until yumi_in; flush_in kills any op.
module divide_rv #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int ROB_W          = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  output logic              ready,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   dividend,
  input  logic [XLEN-1:0]   divisor,
  input  logic [ROB_W-1:0]  rs_rob_entry,
  input  logic              flush_in,
  output logic              valid_out,
  input  logic              yumi_in,
  output logic [ROB_W-1:0]  out_rob,
  output logic [XLEN-1:0]   out_result
);

  // XLEN must be a multiple of BITS_PER_CYCLE (1, 2 or 4).
  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e             state_q;
  logic               valid_q;
  logic [ROB_W-1:0]   rob_q;
  logic [XLEN-1:0]    result_q;
  logic [1:0]         op_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic [XLEN-1:0]    div_q;   // divisor magnitude
  logic [XLEN-1:0]    quo_q;   // dividend shifts out MSB-first, quotient shifts in
  logic [XLEN-1:0]    rem_q;   // partial remainder, always < div_q between steps
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               signed_op;
  logic               neg_a_d;
  logic               neg_b_d;
  logic [XLEN-1:0]    a_mag_d;
  logic [XLEN-1:0]    b_mag_d;
  logic               special_d;
  logic [XLEN-1:0]    special_res_d;
  logic [XLEN-1:0]    rem_d;
  logic [XLEN-1:0]    quo_d;
  logic [XLEN-1:0]    quo_fix;
  logic [XLEN-1:0]    rem_fix;
  logic [XLEN-1:0]    fix_res_d;

  // The second term lets a new op enter on the same cycle the result leaves.
  assign ready      = (state_q == IDLE) | ((state_q == DONE) & yumi_in);
  assign accept     = valid_in & ready & ~flush_in;
  assign valid_out  = valid_q;
  assign out_rob    = rob_q;
  assign out_result = result_q;

  // Decode the incoming op: operand signs, magnitudes and trivial-case result.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    special_d     = 1'b0;
    special_res_d = '0;
    signed_op     = ~op[0];
    neg_a_d       = signed_op & dividend[XLEN-1];
    neg_b_d       = signed_op & divisor[XLEN-1];
    // -INT_MIN wraps to itself, which read unsigned is exactly 2^(XLEN-1).
    a_mag_d       = neg_a_d ? -dividend : dividend;
    b_mag_d       = neg_b_d ? -divisor  : divisor;
    if (divisor == '0) begin
      special_d     = 1'b1;
      special_res_d = op[1] ? dividend : '1;
    end else if (signed_op && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1)) begin
      special_d     = 1'b1;
      special_res_d = op[1] ? '0 : dividend;
    end else if (b_mag_d > a_mag_d) begin
      special_d     = 1'b1;
      special_res_d = op[1] ? dividend : '0;
    end
  end

  // One RUN cycle: BITS_PER_CYCLE restoring steps on an XLEN+1 bit remainder.
  always_comb begin
    logic [XLEN:0]   rem_t;
    logic [XLEN-1:0] quo_t;
    // NOTE: blocking assignments here chain the steps within one cycle; the
    // registers they feed are only ever updated with <= in the always_ff.
    rem_t = {1'b0, rem_q};
    quo_t = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_t = {rem_t[XLEN-1:0], quo_t[XLEN-1]};
      quo_t = {quo_t[XLEN-2:0], 1'b0};
      if (rem_t >= {1'b0, div_q}) begin
        rem_t    = rem_t - {1'b0, div_q};
        quo_t[0] = 1'b1;
      end
    end
    rem_d = rem_t[XLEN-1:0];
    quo_d = quo_t;
  end

  // Sign correction applied in FIX; unsigned ops pass straight through.
  always_comb begin
    quo_fix   = (~op_q[0] & (neg_a_q ^ neg_b_q)) ? -quo_q : quo_q;
    rem_fix   = (~op_q[0] & neg_a_q) ? -rem_q : rem_q;
    fix_res_d = op_q[1] ? rem_fix : quo_fix;
  end

  // Control FSM and datapath registers; flush beats accept and yumi.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the datapath is a handful of flops, not a memory, so it is
      // cleared with the control state for deterministic outputs after reset.
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      rob_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else if (flush_in) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else if (accept) begin
      op_q    <= op;
      rob_q   <= rs_rob_entry;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      div_q   <= b_mag_d;
      quo_q   <= a_mag_d;
      rem_q   <= '0;
      cnt_q   <= CNT_W'(N - 1);
      if (special_d) begin
        result_q <= special_res_d;
        valid_q  <= 1'b1;
        state_q  <= DONE;
      end else begin
        valid_q  <= 1'b0;
        state_q  <= RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        FIX: begin
          result_q <= fix_res_d;
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          if (yumi_in) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_rv.sv
// Directed bench for divide_rv: main unit at XLEN=32/BPC=1, plus BPC=4 and
// XLEN=16/BPC=2 instances for latency and narrow-width signed results.
module tb_divide_rv;

  localparam int LIMIT = 100;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance, XLEN=32, BPC=1
  logic        v0, rdy0, fl0, vo0, yu0;
  logic [1:0]  op0;
  logic [31:0] a0, b0, res0;
  logic [3:0]  tag0, rob0;

  divide_rv #(.XLEN(32), .BITS_PER_CYCLE(1), .ROB_W(4)) u0 (
    .clk(clk), .reset_n(reset_n), .valid_in(v0), .ready(rdy0), .op(op0),
    .dividend(a0), .divisor(b0), .rs_rob_entry(tag0), .flush_in(fl0),
    .valid_out(vo0), .yumi_in(yu0), .out_rob(rob0), .out_result(res0));

  // XLEN=32, BPC=4
  logic        v4, rdy4, fl4, vo4, yu4;
  logic [1:0]  op4;
  logic [31:0] a4, b4, res4;
  logic [3:0]  tag4, rob4;

  divide_rv #(.XLEN(32), .BITS_PER_CYCLE(4), .ROB_W(4)) u4 (
    .clk(clk), .reset_n(reset_n), .valid_in(v4), .ready(rdy4), .op(op4),
    .dividend(a4), .divisor(b4), .rs_rob_entry(tag4), .flush_in(fl4),
    .valid_out(vo4), .yumi_in(yu4), .out_rob(rob4), .out_result(res4));

  // XLEN=16, BPC=2
  logic        v16, rdy16, fl16, vo16, yu16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  tag16, rob16;

  divide_rv #(.XLEN(16), .BITS_PER_CYCLE(2), .ROB_W(4)) u16 (
    .clk(clk), .reset_n(reset_n), .valid_in(v16), .ready(rdy16), .op(op16),
    .dividend(a16), .divisor(b16), .rs_rob_entry(tag16), .flush_in(fl16),
    .valid_out(vo16), .yumi_in(yu16), .out_rob(rob16), .out_result(res16));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t);
    op0 = o; a0 = a; b0 = b; tag0 = t; v0 = 1'b1;
  endtask

  // Called in cycle 1 (first cycle after the accept edge); returns the cycle
  // in which valid_out is first seen high, or LIMIT on timeout.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!vo0 && lat < LIMIT) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input string name);
    yu0 = 1'b1;
    tick();
    yu0 = 1'b0;
    check({name, " released"}, vo0, 0);
  endtask

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t,
                       input int exp_lat, input logic [31:0] exp_res);
    int lat;
    check({name, " ready"}, rdy0, 1);
    drive(o, a, b, t);
    tick();
    v0 = 1'b0;
    wait_valid(lat);
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, res0, exp_res);
    check({name, " rob"}, rob0, t);
    consume(name);
  endtask

  initial begin
    int lat;
    int highs;

    reset_n = 1'b0;
    {v0, fl0, yu0, op0, a0, b0, tag0} = '0;
    {v4, fl4, yu4, op4, a4, b4, tag4} = '0;
    {v16, fl16, yu16, op16, a16, b16, tag16} = '0;
    repeat (3) tick();
    check("reset ready", rdy0, 1);
    check("reset valid_out", vo0, 0);
    check("reset out_rob", rob0, 0);
    check("reset out_result", res0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // DIV 100/3, tag 5, then hold three cycles without yumi
    drive(2'b00, 32'd100, 32'd3, 4'd5);
    tick();
    v0 = 1'b0;
    wait_valid(lat);
    check("div100/3 latency", lat, 34);
    check("div100/3 result", res0, 33);
    check("div100/3 rob", rob0, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold valid_out", vo0, 1);
      check("hold result", res0, 33);
      check("hold rob", rob0, 5);
    end
    consume("div100/3");
    check("idle after yumi ready", rdy0, 1);

    // Signed and unsigned normal-path ops
    do_op("rem -100%3",   2'b10, 32'hFFFF_FF9C, 32'd3,          4'd1, 34, 32'hFFFF_FFFF);
    do_op("div -100/-3",  2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFFD,  4'd2, 34, 32'd33);
    do_op("div 100/-3",   2'b00, 32'd100,       32'hFFFF_FFFD,  4'd3, 34, 32'hFFFF_FFDF);
    do_op("remu ~0%10",   2'b11, 32'hFFFF_FFFF, 32'd10,         4'd4, 34, 32'd5);
    do_op("divu 7/7",     2'b01, 32'd7,         32'd7,          4'd6, 34, 32'd1);

    // Early-out cases, valid_out in cycle 1
    do_op("div 12345/0",  2'b00, 32'd12345,     32'd0,          4'd7, 1, 32'hFFFF_FFFF);
    do_op("remu 12345/0", 2'b11, 32'd12345,     32'd0,          4'd8, 1, 32'd12345);
    do_op("div ovf",      2'b00, 32'h8000_0000, 32'hFFFF_FFFF,  4'd9, 1, 32'h8000_0000);
    do_op("rem ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  4'd10, 1, 32'd0);
    do_op("divu 3/7",     2'b01, 32'd3,         32'd7,          4'd11, 1, 32'd0);
    do_op("remu 3/7",     2'b11, 32'd3,         32'd7,          4'd12, 1, 32'd3);
    do_op("rem -3%7",     2'b10, 32'hFFFF_FFFD, 32'd7,          4'd13, 1, 32'hFFFF_FFFD);

    // Flush in cycle 10 of a DIV
    drive(2'b00, 32'd1000, 32'd7, 4'd14);
    tick();
    v0 = 1'b0;
    repeat (9) tick();
    check("pre-flush valid_out", vo0, 0);
    fl0 = 1'b1;
    tick();
    fl0 = 1'b0;
    check("post-flush ready", rdy0, 1);
    check("post-flush valid_out", vo0, 0);
    highs = 0;
    repeat (40) begin
      tick();
      if (vo0) highs++;
    end
    check("flushed op silent", highs, 0);
    do_op("divu 7/2 after flush", 2'b01, 32'd7, 32'd2, 4'd15, 34, 32'd3);

    // Flush during DONE, with a special-case op presented in the same cycle
    drive(2'b01, 32'd50, 32'd5, 4'd1);
    tick();
    v0 = 1'b0;
    wait_valid(lat);
    check("divu 50/5 result", res0, 10);
    fl0 = 1'b1;
    drive(2'b00, 32'd5, 32'd0, 4'd2);
    tick();
    fl0 = 1'b0;
    v0 = 1'b0;
    check("flush in DONE valid_out", vo0, 0);
    check("flush in DONE ready", rdy0, 1);
    tick();
    check("op in flush cycle dropped", vo0, 0);

    // Back-to-back handoff into a special-case op
    drive(2'b01, 32'd20, 32'd6, 4'd7);
    tick();
    v0 = 1'b0;
    wait_valid(lat);
    check("divu 20/6 result", res0, 3);
    yu0 = 1'b1;
    drive(2'b01, 32'd9, 32'd0, 4'd9);
    #1;
    check("b2b ready with yumi", rdy0, 1);
    tick();
    yu0 = 1'b0;
    v0 = 1'b0;
    check("b2b special valid_out", vo0, 1);
    check("b2b special result", res0, 32'hFFFF_FFFF);
    check("b2b special rob", rob0, 9);
    consume("b2b special");

    // Back-to-back handoff into a normal-path op
    drive(2'b01, 32'd20, 32'd6, 4'd7);
    tick();
    v0 = 1'b0;
    wait_valid(lat);
    yu0 = 1'b1;
    drive(2'b01, 32'd21, 32'd4, 4'd3);
    tick();
    yu0 = 1'b0;
    v0 = 1'b0;
    check("b2b normal gap", vo0, 0);
    wait_valid(lat);
    check("b2b normal latency", lat, 34);
    check("b2b normal result", res0, 5);
    check("b2b normal rob", rob0, 3);
    consume("b2b normal");

    // yumi while idle is ignored
    yu0 = 1'b1;
    tick();
    yu0 = 1'b0;
    check("stray yumi valid_out", vo0, 0);
    check("stray yumi ready", rdy0, 1);

    // BPC=4: DIVU 0xFFFFFFFF/7
    op4 = 2'b01; a4 = 32'hFFFF_FFFF; b4 = 32'd7; tag4 = 4'd2; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    lat = 1;
    while (!vo4 && lat < LIMIT) begin
      tick();
      lat++;
    end
    check("bpc4 latency", lat, 10);
    check("bpc4 result", res4, 32'h2492_4924);
    check("bpc4 rob", rob4, 2);
    yu4 = 1'b1;
    tick();
    yu4 = 1'b0;

    // XLEN=16, BPC=2: DIV 0x8000/2
    op16 = 2'b00; a16 = 16'h8000; b16 = 16'd2; tag16 = 4'd3; v16 = 1'b1;
    tick();
    v16 = 1'b0;
    lat = 1;
    while (!vo16 && lat < LIMIT) begin
      tick();
      lat++;
    end
    check("x16 latency", lat, 10);
    check("x16 result", res16, 16'hC000);
    yu16 = 1'b1;
    tick();
    yu16 = 1'b0;

    // Asynchronous reset in the middle of RUN
    drive(2'b00, 32'd100, 32'd3, 4'd5);
    tick();
    v0 = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check("async reset ready", rdy0, 1);
    check("async reset valid_out", vo0, 0);
    check("async reset result", res0, 0);
    #3;
    reset_n = 1'b1;
    highs = 0;
    repeat (40) begin
      tick();
      if (vo0) highs++;
    end
    check("no stale result after reset", highs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
